// File: rtl/koopa_rom_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : koopa_rom_arbiter_if
// Purpose  : Bundles both sprite renderer fetch ports and the koopa ROM port.
// Revision : 1.0 - initial release
// ============================================================================
interface koopa_rom_arbiter_if;
    // player 0 render pipeline
    logic        req0;
    logic [3:0]  frame0;
    logic [4:0]  px0;
    logic [4:0]  py0;
    logic        gnt0;
    logic        rvalid0;
    logic [5:0]  rdata0;
    // player 1 render pipeline
    logic        req1;
    logic [3:0]  frame1;
    logic [4:0]  px1;
    logic [4:0]  py1;
    logic        gnt1;
    logic        rvalid1;
    logic [5:0]  rdata1;
    // shared sprite ROM
    logic [13:0] rom_addr;
    logic        rom_player;
    logic [5:0]  rom_rgb;

    modport slave (
        input  req0, frame0, px0, py0,
        input  req1, frame1, px1, py1,
        input  rom_rgb,
        output gnt0, rvalid0, rdata0,
        output gnt1, rvalid1, rdata1,
        output rom_addr, rom_player
    );

    modport master (
        output req0, frame0, px0, py0,
        output req1, frame1, px1, py1,
        output rom_rgb,
        input  gnt0, rvalid0, rdata0,
        input  gnt1, rvalid1, rdata1,
        input  rom_addr, rom_player
    );
endinterface
`default_nettype wire

// File: rtl/koopa_rom_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : koopa_rom_arbiter
// Purpose  : Round-robin share of the koopa sprite ROM between two renderers,
//            with fixed two-cycle grant-to-data return.
// Revision : 1.0 - initial release
// ============================================================================
module koopa_rom_arbiter #(
    parameter int         SPR_W       = 23,
    parameter int         SPR_H       = 30,
    parameter int         NUM_FRAMES  = 14,
    parameter logic [5:0] TRANSPARENT = 6'b110011
) (
    input wire                 clk,
    input wire                 rst_n,
    koopa_rom_arbiter_if.slave bus
);

    localparam logic [13:0] c_FRAME_WORDS = 14'(SPR_W * SPR_H);
    localparam logic [13:0] c_ROW_WORDS   = 14'(SPR_W);
    localparam logic [4:0]  c_MAX_FRAMES  = 5'(NUM_FRAMES);
    localparam logic [4:0]  c_MAX_PX      = 5'(SPR_W);
    localparam logic [4:0]  c_MAX_PY      = 5'(SPR_H);

    logic        r_ptr;
    logic [13:0] r_rom_addr;
    logic        r_rom_player;
    logic        r_s1_valid;
    logic        r_s1_id;
    logic        r_s1_oor;
    logic        r_s2_valid;
    logic        r_s2_id;
    logic        r_s2_oor;
    logic [5:0]  r_hold0;
    logic [5:0]  r_hold1;

    logic        w_gnt0;
    logic        w_gnt1;
    logic        w_any;
    logic [3:0]  w_frame;
    logic [4:0]  w_px;
    logic [4:0]  w_py;
    logic        w_oor;
    logic [13:0] w_addr;
    logic        w_ret0;
    logic        w_ret1;
    logic [5:0]  w_pix;

    // Pointer only breaks ties; a lone requester always wins.
    assign w_gnt0 = bus.req0 & (~bus.req1 | ~r_ptr);
    assign w_gnt1 = bus.req1 & (~bus.req0 |  r_ptr);
    assign w_any  = w_gnt0 | w_gnt1;

    assign w_frame = w_gnt1 ? bus.frame1 : bus.frame0;
    assign w_px    = w_gnt1 ? bus.px1    : bus.px0;
    assign w_py    = w_gnt1 ? bus.py1    : bus.py0;

    assign w_oor  = ({1'b0, w_frame} >= c_MAX_FRAMES) |
                    (w_px >= c_MAX_PX) |
                    (w_py >= c_MAX_PY);
    assign w_addr = 14'(w_frame) * c_FRAME_WORDS +
                    14'(w_py)    * c_ROW_WORDS   +
                    14'(w_px);

    // Stage 2 lines up with the ROM's registered output.
    assign w_ret0 = r_s2_valid & ~r_s2_id;
    assign w_ret1 = r_s2_valid &  r_s2_id;
    assign w_pix  = r_s2_oor ? TRANSPARENT : bus.rom_rgb;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr        <= 1'b0;
            r_rom_addr   <= 14'd0;
            r_rom_player <= 1'b0;
            r_s1_valid   <= 1'b0;
            r_s1_id      <= 1'b0;
            r_s1_oor     <= 1'b0;
            r_s2_valid   <= 1'b0;
            r_s2_id      <= 1'b0;
            r_s2_oor     <= 1'b0;
            r_hold0      <= 6'd0;
            r_hold1      <= 6'd0;
        end else begin
            if (bus.req0 && bus.req1) begin
                r_ptr <= ~r_ptr;
            end
            if (w_any) begin
                r_rom_player <= w_gnt1;
                if (!w_oor) begin
                    r_rom_addr <= w_addr;
                end
            end
            r_s1_valid <= w_any;
            r_s1_id    <= w_gnt1;
            r_s1_oor   <= w_oor;
            r_s2_valid <= r_s1_valid;
            r_s2_id    <= r_s1_id;
            r_s2_oor   <= r_s1_oor;
            if (w_ret0) begin
                r_hold0 <= w_pix;
            end
            if (w_ret1) begin
                r_hold1 <= w_pix;
            end
        end
    end

    assign bus.gnt0       = w_gnt0;
    assign bus.gnt1       = w_gnt1;
    assign bus.rom_addr   = r_rom_addr;
    assign bus.rom_player = r_rom_player;
    assign bus.rvalid0    = w_ret0;
    assign bus.rvalid1    = w_ret1;
    // Returned pixel passes straight from the ROM register; hold keeps it afterwards.
    assign bus.rdata0     = w_ret0 ? w_pix : r_hold0;
    assign bus.rdata1     = w_ret1 ? w_pix : r_hold1;

endmodule
`default_nettype wire

// File: tb/tb_koopa_rom_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_koopa_rom_arbiter
// Purpose  : Randomized and directed self-checking bench for koopa_rom_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_koopa_rom_arbiter;

    localparam logic [5:0] c_TRANS = 6'b110011;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    bit   check_en = 1'b0;
    int   n_pass  = 0;
    int   n_total = 0;

    koopa_rom_arbiter_if bus ();

    koopa_rom_arbiter dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Sprite ROM contents: arbitrary but address- and palette-dependent.
    function automatic logic [5:0] rom_fn(input logic [13:0] a, input logic p);
        logic [13:0] t;
        t = a * 14'd7 + (a >> 6) + 14'd5;
        return t[5:0] ^ (p ? 6'h2A : 6'h00);
    endfunction

    always @(posedge clk) bus.rom_rgb <= rom_fn(bus.rom_addr, bus.rom_player);

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        int due;
        int id;
        int data;
    } ret_t;

    ret_t ret_q[$];
    int   cyc = 0;
    int   m_ptr = 0;
    int   m_addr = 0;
    int   m_player = 0;
    int   m_last0 = 0;
    int   m_last1 = 0;
    int   e_g0, e_g1, e_rv0, e_rv1, e_rd0, e_rd1;
    int   m_id, m_f, m_x, m_y;
    bit   m_oor;

    always @(negedge clk) begin
        if (check_en) begin
            if (!rst_n) begin
                ret_q.delete();
                m_ptr = 0; m_addr = 0; m_player = 0; m_last0 = 0; m_last1 = 0;
            end
            e_g0 = (bus.req0 && (!bus.req1 || m_ptr == 0)) ? 1 : 0;
            e_g1 = (bus.req1 && (!bus.req0 || m_ptr == 1)) ? 1 : 0;
            e_rv0 = 0; e_rv1 = 0;
            if (ret_q.size() > 0 && ret_q[0].due == cyc) begin
                if (ret_q[0].id == 0) begin e_rv0 = 1; m_last0 = ret_q[0].data; end
                else                  begin e_rv1 = 1; m_last1 = ret_q[0].data; end
                void'(ret_q.pop_front());
            end
            e_rd0 = m_last0;
            e_rd1 = m_last1;
            chk("gnt0",       int'(bus.gnt0),       e_g0);
            chk("gnt1",       int'(bus.gnt1),       e_g1);
            chk("rom_addr",   int'(bus.rom_addr),   m_addr);
            chk("rom_player", int'(bus.rom_player), m_player);
            chk("rvalid0",    int'(bus.rvalid0),    e_rv0);
            chk("rvalid1",    int'(bus.rvalid1),    e_rv1);
            chk("rdata0",     int'(bus.rdata0),     e_rd0);
            chk("rdata1",     int'(bus.rdata1),     e_rd1);
            if (rst_n && (e_g0 == 1 || e_g1 == 1)) begin
                m_id  = e_g1;
                m_f   = m_id ? int'(bus.frame1) : int'(bus.frame0);
                m_x   = m_id ? int'(bus.px1)    : int'(bus.px0);
                m_y   = m_id ? int'(bus.py1)    : int'(bus.py0);
                m_oor = (m_f >= 14) || (m_x >= 23) || (m_y >= 30);
                if (!m_oor) m_addr = m_f * 690 + m_y * 23 + m_x;
                m_player = m_id;
                ret_q.push_back('{cyc + 2, m_id,
                                  m_oor ? int'(c_TRANS) : int'(rom_fn(14'(m_addr), 1'(m_id)))});
                if (bus.req0 && bus.req1) m_ptr = 1 - m_ptr;
            end
            cyc++;
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive(input int id, input bit rq, input int f, input int x, input int y);
        if (id == 0) begin
            bus.req0 = rq; bus.frame0 = 4'(f); bus.px0 = 5'(x); bus.py0 = 5'(y);
        end else begin
            bus.req1 = rq; bus.frame1 = 4'(f); bus.px1 = 5'(x); bus.py1 = 5'(y);
        end
    endtask

    // Called and returns at posedge+1; pins literal addresses and data.
    task automatic single(input int id, input int f, input int x, input int y,
                          input int exp_addr, input bit oor);
        drive(id, 1'b1, f, x, y);
        @(negedge clk);
        chk("lone_gnt", id ? int'(bus.gnt1) : int'(bus.gnt0), 1);
        @(posedge clk); #1;
        if (id == 0) bus.req0 = 1'b0; else bus.req1 = 1'b0;
        @(negedge clk);
        chk("lit_addr", int'(bus.rom_addr), exp_addr);
        chk("lit_player", int'(bus.rom_player), id);
        @(negedge clk);
        chk("lit_rvalid", id ? int'(bus.rvalid1) : int'(bus.rvalid0), 1);
        chk("lit_rdata", id ? int'(bus.rdata1) : int'(bus.rdata0),
            oor ? int'(c_TRANS) : int'(rom_fn(14'(exp_addr), 1'(id))));
        @(posedge clk); #1;
    endtask

    bit s0, s1;

    initial begin
        drive(0, 1'b0, 0, 0, 0);
        drive(1, 1'b0, 0, 0, 0);
        #1 rst_n = 1'b0;
        check_en = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // lone requests, address extremes and out-of-range tagging
        single(0, 0, 0, 0, 0, 1'b0);
        single(1, 13, 22, 29, 9659, 1'b0);
        single(0, 14, 0, 0, 9659, 1'b1);
        single(0, 0, 23, 0, 9659, 1'b1);
        single(0, 0, 0, 30, 9659, 1'b1);
        repeat (2) @(posedge clk);
        #1;

        // contention: pointer alternates 0,1,0,1
        drive(0, 1'b1, 1, 3, 4);
        drive(1, 1'b1, 5, 10, 20);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("rr_gnt0", int'(bus.gnt0), (i % 2 == 0) ? 1 : 0);
            @(posedge clk); #1;
        end
        bus.req0 = 1'b0; bus.req1 = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        // streaming: one grant per cycle to a lone requester
        for (int x = 0; x < 23; x++) begin
            drive(0, 1'b1, 2, x, 5);
            @(negedge clk);
            chk("stream_gnt0", int'(bus.gnt0), 1);
            @(posedge clk); #1;
        end
        bus.req0 = 1'b0;
        @(negedge clk);
        chk("stream_last_addr", int'(bus.rom_addr), 1517);
        @(posedge clk); #1;

        // randomized traffic with hold-until-grant and occasional legal drops
        s0 = 1'b0; s1 = 1'b0;
        for (int i = 0; i < 800; i++) begin
            if (!bus.req0 || s0)
                drive(0, $urandom_range(0, 3) != 0,
                      ($urandom_range(0, 7) == 0) ? $urandom_range(14, 15) : $urandom_range(0, 13),
                      ($urandom_range(0, 7) == 0) ? $urandom_range(23, 31) : $urandom_range(0, 22),
                      ($urandom_range(0, 7) == 0) ? $urandom_range(30, 31) : $urandom_range(0, 29));
            else if ($urandom_range(0, 15) == 0)
                bus.req0 = 1'b0;
            if (!bus.req1 || s1)
                drive(1, $urandom_range(0, 3) != 0,
                      ($urandom_range(0, 7) == 0) ? $urandom_range(14, 15) : $urandom_range(0, 13),
                      ($urandom_range(0, 7) == 0) ? $urandom_range(23, 31) : $urandom_range(0, 22),
                      ($urandom_range(0, 7) == 0) ? $urandom_range(30, 31) : $urandom_range(0, 29));
            else if ($urandom_range(0, 15) == 0)
                bus.req1 = 1'b0;
            @(negedge clk);
            s0 = bus.gnt0;
            s1 = bus.gnt1;
            @(posedge clk); #1;
        end
        bus.req0 = 1'b0; bus.req1 = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        // leave the pointer at requester 1 so a reset of it is observable
        drive(0, 1'b1, 0, 1, 1);
        drive(1, 1'b1, 0, 2, 2);
        @(negedge clk);
        s1 = bus.gnt1;
        @(posedge clk); #1;
        if (s1) begin
            @(negedge clk);
            @(posedge clk); #1;
        end
        bus.req0 = 1'b0; bus.req1 = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        // grant then async reset while the read is in flight
        drive(1, 1'b1, 3, 1, 1);
        @(negedge clk);
        @(posedge clk); #1;
        bus.req1 = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("rst_addr", int'(bus.rom_addr), 0);
        chk("rst_player", int'(bus.rom_player), 0);
        chk("rst_rvalid1", int'(bus.rvalid1), 0);
        drive(0, 1'b1, 4, 4, 4);
        drive(1, 1'b1, 6, 6, 6);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_gnt0", int'(bus.gnt0), 1);
        @(posedge clk); #1;
        bus.req0 = 1'b0; bus.req1 = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check_en = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/koopa_rom_arbiter.md
Name: koopa_rom_arbiter

Overview:
- Shares the single koopa sprite ROM (23x30 px frames, 14 frames, 1-cycle registered read, per-read player palette bit) between the two player sprite renderers.
- Arbitrates round-robin between requests and computes the linear ROM address from (frame, x, y).
- Drives the palette select from the winning requester's id, then returns the pixel colour to that requester with fixed latency.
- Sits between both player render pipelines and the one ROM instance, so the ROM is not duplicated per player.

Parameters:
- SPR_W, 23, sprite width in pixels.
- SPR_H, 30, sprite height in pixels.
- NUM_FRAMES, 14, animation frames stored in ROM (SPR_W*SPR_H*NUM_FRAMES = 9660 words).
- TRANSPARENT, 6'b110011, colour returned for out-of-range requests (ROM palette index 0 colour).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- req0  in  1  player-0 fetch request
- frame0  in  4  player-0 frame index
- px0  in  5  player-0 pixel column
- py0  in  5  player-0 pixel row
- gnt0  out  1  player-0 request accepted this cycle
- rvalid0  out  1  player-0 read data valid
- rdata0  out  6  player-0 RGB222 pixel
- req1, frame1, px1, py1, gnt1, rvalid1, rdata1  same as player 0, for player 1
- rom_addr  out  14  ROM address
- rom_player  out  1  ROM palette select (0 = player 0, 1 = player 1)
- rom_rgb  in  6  ROM registered colour output

Behaviour:
- Reset (async, rst_n=0):
  - rom_addr=0, rom_player=0, rvalid0/1=0, rdata0/1=0.
  - Priority pointer = requester 0.
  - Pipeline valid bits cleared; in-flight reads are discarded and produce no rvalid after reset release.
- Handshake:
  - A requester holds req and its frame/px/py stable until it sees gnt.
  - gnt is combinational, asserted in the same cycle as the accepted req.
  - At most one gnt per cycle.
- Arbitration:
  - Only one req high -> that requester is granted.
  - Both high -> the pointer's requester is granted, and the pointer moves to the other requester.
  - The pointer does not change when fewer than two requests are pending.
  - A lone requester can be granted every cycle (throughput 1 pixel/cycle).
- Address, registered on the grant edge (end of cycle T):
  - rom_addr = frame*SPR_W*SPR_H + py*SPR_W + px, computed in 14 bits, max 9659.
  - rom_player <= granted id.
  - rom_addr/rom_player hold their last value when there is no grant.
- Range check:
  - frame >= NUM_FRAMES, px >= SPR_W or py >= SPR_H -> request is still granted, but the pipeline tags it out-of-range.
  - rom_addr holds its previous value for that request.
  - The returned data is TRANSPARENT.
- Pipeline: stage 1 = {valid, id, oor} registered at the end of T; stage 2 registered at the end of T+1, aligned with rom_rgb.
- Return (cycle T+2):
  - rvalid<id>=1 for exactly one cycle.
  - rdata<id> = TRANSPARENT if oor, else rom_rgb.
  - rdata is registered and holds its last value when rvalid=0.
- Latency: fixed 2 cycles from grant to rvalid, regardless of contention.
- Ordering: returns per requester are in grant order.
- Back-to-back grants to alternating requesters produce alternating rvalid0/rvalid1 on consecutive cycles.
- Simultaneous req edge cases:
  - A req dropped without gnt is legal and is never serviced.
  - A req held across reset release is arbitrated fresh, with pointer = 0.

Test Plan:
- Reset then req0 only, frame0=0, px0=0, py0=0 -> gnt0 same cycle; rom_addr=0 and rom_player=0 next cycle; rvalid0=1 two cycles after grant with rdata0 = the driven rom_rgb; rvalid1 stays 0.
- req1 only, frame1=13, px1=22, py1=29 -> rom_addr=9659, rom_player=1, rvalid1 at T+2 with rdata1=rom_rgb.
- req0 and req1 held high for 4 cycles after reset -> gnt order 0,1,0,1; rom_player 0,1,0,1; rvalid0 and rvalid1 alternate starting 2 cycles after the first grant; each rdata matches the ROM model for its own address.
- req0 with frame0=14 (also px0=23, and separately py0=30) -> gnt0 asserted; rom_addr unchanged; rdata0=6'b110011 with rvalid0 at T+2.
- req0 held continuously with px0 stepping 0..22 on each gnt, frame0=2, py0=5 -> 23 consecutive grants; rom_addr = 1495..1517; 23 consecutive rvalid0 pulses with correct data.
- Assert rst_n low one cycle after a grant -> all outputs 0 immediately (async); no rvalid after release; pointer is back to 0, so both requesting grants 0 first.
